zmc2_dot_ser: RTL and testbench
===============================

// Module: zmc2_dot_ser
// PURPOSE
//  Parametrised bitplane-to-pixel serializer for the sprite path.
//  - Takes packed graphics words from the C-ROM fetch path through a valid/ready handshake.
//  - Buffers up to two words: one active word plus one holding word.
//  - Each enabled cycle, emits CHANNELS pixels with colour index and opacity flag, feeding the line-buffer lanes.
//  - Adds over the fixed serializer: per-word latched flip/parity attributes, prefetch buffering, gap-free back-to-back words, and underrun detection.
// PARAMETERS
//  BPP           4  bits per pixel (number of bitplanes)
//  PIX_PER_WORD  8  pixels per input word; must be a multiple of CHANNELS
//  CHANNELS      2  pixels emitted per enabled cycle (output lanes)
// PORTS
//  CLK_12M     in   1                    pixel clock; all logic on rising edge
//  RESET       in   1                    synchronous, active-high reset
//  LOAD_VALID  in   1                    CR/H/EVEN valid this cycle
//  LOAD_READY  out  1                    block can accept a word this cycle
//  CR          in   BPP*PIX_PER_WORD     plane-major word: plane b at CR[b*P +: P]; pixel p bit b = CR[b*P+p]
//  H           in   1                    horizontal flip for this word (1 = pixel P-1 first)
//  EVEN        in   1                    lane order for this word (1 = reverse lane order)
//  PIX_EN      in   1                    consume one slice this cycle
//  PIX_VALID   out  1                    GD/DOT hold a valid slice
//  GD          out  CHANNELS*BPP         lane c colour index at GD[c*BPP +: BPP]
//  DOT         out  CHANNELS             lane c opaque, i.e. |GD lane c
//  UNDERRUN    out  1                    one-cycle pulse: PIX_EN with no active word
//  BUSY        out  1                    active or holding word present
// BEHAVIOUR
//  - Definitions: P = PIX_PER_WORD; S = P/CHANNELS slices per word; slice counter width = max(1, clog2(S)).
//  - Handshake and storage:
//    - A load is accepted when LOAD_VALID and LOAD_READY are both high.
//    - CR, H and EVEN are captured together on acceptance.
//    - Later changes on H or EVEN never affect an already accepted word.
//    - LOAD_READY = !hold_valid || (hold moves to active this cycle). It is combinational from internal state and PIX_EN only, never from LOAD_VALID.
//    - When the active register is empty, an accepted word goes straight to active, bypassing hold; it becomes active the next cycle.
//  - Emission, when PIX_EN and the active register is valid:
//    - Slice k covers pixel indices q = k*CHANNELS + c, for c = 0..CHANNELS-1.
//    - Source pixel: H=0 gives q; H=1 gives P-1-q.
//    - Lane mapping: EVEN=0 puts source q on lane c; EVEN=1 puts it on lane CHANNELS-1-c.
//    - GD and DOT are registered and appear 1 cycle after the PIX_EN cycle; PIX_VALID follows the same timing.
//    - The slice counter increments. On k = S-1 the active word retires.
//  - Retire and promote:
//    - If hold is valid, hold moves to active in the same cycle with the counter cleared. There is no bubble between words.
//    - Simultaneously with that promotion, a new load may be accepted into hold.
//  - Idle cases:
//    - PIX_EN low: counter and outputs hold; PIX_VALID falls to 0 the next cycle.
//    - PIX_EN with active invalid: UNDERRUN = 1 next cycle, PIX_VALID = 0, GD and DOT hold their last values.
//  - Reset values: PIX_VALID=0, GD=0, DOT=0, UNDERRUN=0, BUSY=0, LOAD_READY=1 in the cycle after reset. Active, hold and counter are cleared.
//  - Reset mid-word: any partially emitted word and the held word are discarded. A load presented in the reset cycle is ignored.
//  - No other mode or state exists. The state machine is implicit: EMPTY → ACTIVE → ACTIVE+HOLD, driven by the two valid bits.
// STRUCTURE
//  - Shared package zmc2_pkg:
//    - Default BPP, PIX_PER_WORD and CHANNELS constants.
//    - Function pix_of(word, idx) returning a BPP-bit colour from a plane-major word.
//    - Elaboration check that PIX_PER_WORD % CHANNELS == 0.
//  - One sub-module, zmc2_dot_lane_mux: a combinational slice/flip/lane selector, instantiated once, producing the CHANNELS*BPP pre-register bus.
//  - The top level holds the two word registers, valid bits, slice counter, handshake and output registers.
// TESTING (defaults BPP=4, P=8, CHANNELS=2; CR=32'h00F0CCAA means pixel p = p)
//  1. Load CR with H=0, EVEN=0, then PIX_EN for 4 cycles → lane0 = 0,2,4,6; lane1 = 1,3,5,7; DOT = 2'b10 on the first slice, then 2'b11.
//  2. Same word with H=1, EVEN=0 → lane0 = 7,5,3,1; lane1 = 6,4,2,0. With H=1, EVEN=1 → lane0 = 6,4,2,0; lane1 = 7,5,3,1.
//  3. Two words back-to-back with PIX_EN held high → 8 consecutive PIX_VALID cycles. LOAD_READY is low while hold is full and returns high in the promote cycle.
//  4. Toggle H and EVEN after acceptance, mid-word → output order is unchanged for that word.
//  5. PIX_EN with no word loaded → UNDERRUN pulses for 1 cycle, PIX_VALID = 0, GD unchanged.
//  6. RESET asserted after 2 slices with hold full → next cycle BUSY=0, LOAD_READY=1, PIX_VALID=0. A new load then restarts at slice 0.

Source files
------------

// File: rtl/zmc2_pkg.sv
`default_nettype none
// ============================================================================
// Package  : zmc2_pkg
// Brief    : Shared defaults and helpers for the zmc2 bitplane-to-pixel serializer.
// Revision : 1.0 - initial release
// ============================================================================
package zmc2_pkg;

  localparam int unsigned C_BPP          = 4;
  localparam int unsigned C_PIX_PER_WORD = 8;
  localparam int unsigned C_CHANNELS     = 2;

  // Upper bounds that let pix_of() work on any legal configuration.
  localparam int unsigned C_MAX_BPP  = 8;
  localparam int unsigned C_MAX_WORD = 256;

  // Colour index of pixel idx from a plane-major word: bit b lives at word[b*ppw + idx].
  function automatic logic [C_MAX_BPP-1:0] pix_of(
    input logic [C_MAX_WORD-1:0] word,
    input int unsigned           ppw,
    input int unsigned           bpp,
    input int unsigned           idx
  );
    logic [C_MAX_WORD-1:0] sh;
    logic [C_MAX_BPP-1:0]  r;
    r = '0;
    for (int unsigned b = 0; b < C_MAX_BPP; b++) begin
      if (b < bpp) begin
        sh = word >> (b * ppw + idx);
        r  = r | (C_MAX_BPP'(sh[0]) << b);
      end
    end
    return r;
  endfunction

  function automatic bit cfg_ok(
    input int unsigned bpp,
    input int unsigned ppw,
    input int unsigned ch
  );
    return (ch > 0) && (ppw >= ch) && ((ppw % ch) == 0) &&
           (bpp > 0) && (bpp <= C_MAX_BPP) && ((bpp * ppw) <= C_MAX_WORD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/zmc2_dot_ser_lane_mux.sv
`default_nettype none
// ============================================================================
// Module   : zmc2_dot_lane_mux
// Brief    : Combinational slice / horizontal-flip / lane-order pixel selector.
// Revision : 1.0 - initial release
// ============================================================================
module zmc2_dot_lane_mux
  import zmc2_pkg::*;
#(
  parameter int unsigned BPP          = C_BPP,
  parameter int unsigned PIX_PER_WORD = C_PIX_PER_WORD,
  parameter int unsigned CHANNELS     = C_CHANNELS,
  parameter int unsigned CNT_W        = 2
) (
  input  logic [BPP*PIX_PER_WORD-1:0] word_i,
  input  logic [CNT_W-1:0]            slice_i,
  input  logic                        h_i,
  input  logic                        even_i,
  output logic [CHANNELS*BPP-1:0]     gd_o
);

  for (genvar gl = 0; gl < CHANNELS; gl++) begin : g_lane
    int unsigned      w_q;
    int unsigned      w_src;
    logic [BPP-1:0]   w_pix;

    // Lane gl shows slice position gl, or its mirror within the slice when EVEN is set.
    always_comb begin
      w_q   = 32'(slice_i) * CHANNELS +
              (even_i ? (CHANNELS - 1 - 32'(gl)) : 32'(gl));
      w_src = h_i ? (PIX_PER_WORD - 1 - w_q) : w_q;
      w_pix = BPP'(pix_of(C_MAX_WORD'(word_i), PIX_PER_WORD, BPP, w_src));
    end

    assign gd_o[gl*BPP +: BPP] = w_pix;
  end

endmodule
`default_nettype wire

// File: rtl/zmc2_dot_ser.sv
`default_nettype none
// ============================================================================
// Module   : zmc2_dot_ser
// Brief    : Two-deep buffered bitplane-to-pixel serializer with flip/lane attributes.
// Revision : 1.0 - initial release
// ============================================================================
module zmc2_dot_ser
  import zmc2_pkg::*;
#(
  parameter int unsigned BPP          = C_BPP,
  parameter int unsigned PIX_PER_WORD = C_PIX_PER_WORD,
  parameter int unsigned CHANNELS     = C_CHANNELS
) (
  input  logic                        CLK_12M,
  input  logic                        RESET,
  input  logic                        LOAD_VALID,
  output logic                        LOAD_READY,
  input  logic [BPP*PIX_PER_WORD-1:0] CR,
  input  logic                        H,
  input  logic                        EVEN,
  input  logic                        PIX_EN,
  output logic                        PIX_VALID,
  output logic [CHANNELS*BPP-1:0]     GD,
  output logic [CHANNELS-1:0]         DOT,
  output logic                        UNDERRUN,
  output logic                        BUSY
);

  localparam int unsigned         C_WORD_W = BPP * PIX_PER_WORD;
  localparam int unsigned         C_SLICES = PIX_PER_WORD / CHANNELS;
  localparam int unsigned         C_CNT_W  = (C_SLICES > 1) ? $clog2(C_SLICES) : 1;
  localparam logic [C_CNT_W-1:0]  C_LAST   = C_CNT_W'(C_SLICES - 1);

  if (!cfg_ok(BPP, PIX_PER_WORD, CHANNELS)) begin : g_cfg_check
    $error("zmc2_dot_ser: PIX_PER_WORD must be a multiple of CHANNELS and fit the helper limits");
  end

  logic                    act_valid_q,  act_valid_d;
  logic [C_WORD_W-1:0]     act_word_q,   act_word_d;
  logic                    act_h_q,      act_h_d;
  logic                    act_even_q,   act_even_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [C_WORD_W-1:0]     hold_word_q,  hold_word_d;
  logic                    hold_h_q,     hold_h_d;
  logic                    hold_even_q,  hold_even_d;
  logic [C_CNT_W-1:0]      cnt_q,        cnt_d;
  logic [CHANNELS*BPP-1:0] gd_q,         gd_d;
  logic [CHANNELS-1:0]     dot_q,        dot_d;
  logic                    pv_q,         pv_d;
  logic                    ur_q,         ur_d;

  logic                    w_fire;
  logic                    w_last;
  logic                    w_promote;
  logic                    w_act_free;
  logic                    w_accept;
  logic [CHANNELS*BPP-1:0] w_gd;
  logic [CHANNELS-1:0]     w_dot;

  assign w_fire     = PIX_EN && act_valid_q;
  assign w_last     = w_fire && (cnt_q == C_LAST);
  assign w_promote  = w_last && hold_valid_q;
  // Active slot frees up this cycle if it is empty or retires with nothing queued behind it.
  assign w_act_free = !act_valid_q || (w_last && !hold_valid_q);
  assign LOAD_READY = !hold_valid_q || w_promote;
  assign w_accept   = LOAD_VALID && LOAD_READY;

  zmc2_dot_lane_mux #(
    .BPP          (BPP),
    .PIX_PER_WORD (PIX_PER_WORD),
    .CHANNELS     (CHANNELS),
    .CNT_W        (C_CNT_W)
  ) u_lane_mux (
    .word_i  (act_word_q),
    .slice_i (cnt_q),
    .h_i     (act_h_q),
    .even_i  (act_even_q),
    .gd_o    (w_gd)
  );

  for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_dot
    assign w_dot[gc] = |w_gd[gc*BPP +: BPP];
  end

  always_comb begin
    act_valid_d  = act_valid_q;
    act_word_d   = act_word_q;
    act_h_d      = act_h_q;
    act_even_d   = act_even_q;
    hold_valid_d = hold_valid_q;
    hold_word_d  = hold_word_q;
    hold_h_d     = hold_h_q;
    hold_even_d  = hold_even_q;
    cnt_d        = cnt_q;

    if (w_fire) begin
      if (w_last) begin
        cnt_d = '0;
        if (hold_valid_q) begin
          act_word_d   = hold_word_q;
          act_h_d      = hold_h_q;
          act_even_d   = hold_even_q;
          hold_valid_d = 1'b0;
        end else begin
          act_valid_d  = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + C_CNT_W'(1);
      end
    end

    if (w_accept) begin
      if (w_act_free) begin
        act_valid_d  = 1'b1;
        act_word_d   = CR;
        act_h_d      = H;
        act_even_d   = EVEN;
      end else begin
        hold_valid_d = 1'b1;
        hold_word_d  = CR;
        hold_h_d     = H;
        hold_even_d  = EVEN;
      end
    end
  end

  always_comb begin
    gd_d  = w_fire ? w_gd  : gd_q;
    dot_d = w_fire ? w_dot : dot_q;
    pv_d  = w_fire;
    ur_d  = PIX_EN && !act_valid_q;
  end

  always_ff @(posedge CLK_12M) begin
    if (RESET) begin
      act_valid_q  <= 1'b0;
      act_word_q   <= '0;
      act_h_q      <= 1'b0;
      act_even_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_word_q  <= '0;
      hold_h_q     <= 1'b0;
      hold_even_q  <= 1'b0;
      cnt_q        <= '0;
      gd_q         <= '0;
      dot_q        <= '0;
      pv_q         <= 1'b0;
      ur_q         <= 1'b0;
    end else begin
      act_valid_q  <= act_valid_d;
      act_word_q   <= act_word_d;
      act_h_q      <= act_h_d;
      act_even_q   <= act_even_d;
      hold_valid_q <= hold_valid_d;
      hold_word_q  <= hold_word_d;
      hold_h_q     <= hold_h_d;
      hold_even_q  <= hold_even_d;
      cnt_q        <= cnt_d;
      gd_q         <= gd_d;
      dot_q        <= dot_d;
      pv_q         <= pv_d;
      ur_q         <= ur_d;
    end
  end

  assign PIX_VALID = pv_q;
  assign GD        = gd_q;
  assign DOT       = dot_q;
  assign UNDERRUN  = ur_q;
  assign BUSY      = act_valid_q || hold_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_zmc2_dot_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_zmc2_dot_ser
// Brief    : Directed plus randomized bench for zmc2_dot_ser against a word-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zmc2_dot_ser;

  localparam int BPP = 4;
  localparam int P   = 8;
  localparam int CH  = 2;
  localparam int S   = P / CH;
  localparam logic [31:0] C_RAMP = 32'h00F0CCAA;

  logic           CLK_12M = 1'b0;
  logic           RESET = 1'b1;
  logic           LOAD_VALID = 1'b0;
  logic           LOAD_READY;
  logic [31:0]    CR = '0;
  logic           H = 1'b0;
  logic           EVEN = 1'b0;
  logic           PIX_EN = 1'b0;
  logic           PIX_VALID;
  logic [7:0]     GD;
  logic [1:0]     DOT;
  logic           UNDERRUN;
  logic           BUSY;

  zmc2_dot_ser dut (
    .CLK_12M    (CLK_12M),
    .RESET      (RESET),
    .LOAD_VALID (LOAD_VALID),
    .LOAD_READY (LOAD_READY),
    .CR         (CR),
    .H          (H),
    .EVEN       (EVEN),
    .PIX_EN     (PIX_EN),
    .PIX_VALID  (PIX_VALID),
    .GD         (GD),
    .DOT        (DOT),
    .UNDERRUN   (UNDERRUN),
    .BUSY       (BUSY)
  );

  always #5 CLK_12M = ~CLK_12M;

  typedef struct {
    logic [31:0] cr;
    bit          h;
    bit          even;
  } word_t;

  word_t      m_q[$];
  int         m_k = 0;
  logic       m_pv = 1'b0;
  logic [7:0] m_gd = '0;
  logic [1:0] m_dot = '0;
  logic       m_ur = 1'b0;
  logic       last_ready;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pix(input logic [31:0] cr, input int idx);
    int v = 0;
    for (int b = 0; b < BPP; b++)
      if (cr[b*P + idx]) v += (1 << b);
    return v;
  endfunction

  function automatic bit model_ready();
    return (m_q.size() < 2) || (PIX_EN && m_k == S - 1);
  endfunction

  task automatic model_step(input bit rdy);
    bit fire;
    if (RESET) begin
      m_q.delete();
      m_k = 0; m_pv = 0; m_gd = '0; m_dot = '0; m_ur = 0;
      return;
    end
    fire = PIX_EN && (m_q.size() > 0);
    m_ur = PIX_EN && (m_q.size() == 0);
    m_pv = fire;
    if (fire) begin
      for (int c = 0; c < CH; c++) begin
        int qq, src, lane, v;
        qq   = m_k * CH + c;
        src  = m_q[0].h ? (P - 1 - qq) : qq;
        lane = m_q[0].even ? (CH - 1 - c) : c;
        v    = pix(m_q[0].cr, src);
        m_gd[lane*BPP +: BPP] = 4'(v);
        m_dot[lane] = (v != 0);
      end
      m_k++;
      if (m_k == S) begin
        m_k = 0;
        void'(m_q.pop_front());
      end
    end
    if (LOAD_VALID && rdy) m_q.push_back('{cr: CR, h: H, even: EVEN});
  endtask

  task automatic tick();
    bit rdy;
    #1;
    rdy = model_ready();
    last_ready = LOAD_READY;
    if (!RESET) chk("load_ready", LOAD_READY, rdy);
    model_step(rdy);
    @(posedge CLK_12M);
    #1;
    chk("pix_valid", PIX_VALID, m_pv);
    chk("gd", GD, m_gd);
    chk("dot", DOT, m_dot);
    chk("underrun", UNDERRUN, m_ur);
    chk("busy", BUSY, m_q.size() > 0);
  endtask

  task automatic load(input logic [31:0] cr, input bit h, input bit e);
    LOAD_VALID = 1; CR = cr; H = h; EVEN = e;
    tick();
    LOAD_VALID = 0;
  endtask

  initial begin
    int nv;

    // Reset
    RESET = 1; tick(); tick();
    RESET = 0;
    chk("rst_pix_valid", PIX_VALID, 0);
    chk("rst_gd", GD, 0);
    chk("rst_busy", BUSY, 0);
    tick();
    chk("rst_ready", last_ready, 1);

    // Plain order
    load(C_RAMP, 0, 0);
    PIX_EN = 1;
    tick();
    chk("t1_gd_s0", GD, 8'h10);
    chk("t1_dot_s0", DOT, 2'b10);
    tick();
    chk("t1_gd_s1", GD, 8'h32);
    chk("t1_dot_s1", DOT, 2'b11);
    tick(); tick();
    chk("t1_gd_s3", GD, 8'h76);
    PIX_EN = 0; tick();
    chk("t1_pv_idle", PIX_VALID, 0);

    // Flip, then flip + reversed lanes
    load(C_RAMP, 1, 0);
    PIX_EN = 1; tick();
    chk("t2_h_gd_s0", GD, 8'h67);
    tick(); tick(); tick();
    chk("t2_h_gd_s3", GD, 8'h01);
    PIX_EN = 0;
    load(C_RAMP, 1, 1);
    PIX_EN = 1; tick();
    chk("t2_he_gd_s0", GD, 8'h76);
    tick(); tick(); tick();
    chk("t2_he_gd_s3", GD, 8'h10);
    PIX_EN = 0; tick();

    // Back-to-back with a third word waiting on the promote cycle
    load(C_RAMP, 0, 0);
    load(32'hA5C3_96F0, 1, 0);
    tick();
    chk("t3_ready_full", last_ready, 0);
    nv = 0;
    PIX_EN = 1;
    for (int i = 0; i < 8; i++) begin
      LOAD_VALID = (i <= 3);
      CR = 32'h1234_5678; H = 0; EVEN = 1;
      tick();
      chk("t3_ready", last_ready, (i == 3 || i == 7));
      nv += int'(PIX_VALID);
    end
    LOAD_VALID = 0;
    chk("t3_valid_run", nv, 8);
    tick(); tick(); tick(); tick();
    PIX_EN = 0; tick();
    chk("t3_busy_drained", BUSY, 0);

    // Attributes latched at acceptance
    load(C_RAMP, 0, 0);
    PIX_EN = 1; tick(); tick();
    H = 1; EVEN = 1;
    tick();
    chk("t4_gd_s2", GD, 8'h54);
    tick();
    chk("t4_gd_s3", GD, 8'h76);

    // Underrun
    PIX_EN = 1; tick();
    chk("t5_underrun", UNDERRUN, 1);
    chk("t5_pv", PIX_VALID, 0);
    chk("t5_gd_hold", GD, 8'h76);
    PIX_EN = 0; tick();
    chk("t5_underrun_clear", UNDERRUN, 0);

    // Reset mid-word with hold full
    load(C_RAMP, 0, 0);
    load(32'hFFFF_FFFF, 0, 0);
    PIX_EN = 1; tick(); tick();
    RESET = 1; LOAD_VALID = 1; CR = 32'hDEAD_BEEF;
    tick();
    RESET = 0; LOAD_VALID = 0; PIX_EN = 0;
    chk("t6_busy", BUSY, 0);
    chk("t6_pv", PIX_VALID, 0);
    tick();
    chk("t6_ready", last_ready, 1);
    load(C_RAMP, 0, 0);
    PIX_EN = 1; tick();
    chk("t6_restart_s0", GD, 8'h10);
    PIX_EN = 0; tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      RESET      = ($urandom_range(0, 79) == 0);
      LOAD_VALID = 1'($urandom_range(0, 1));
      CR         = $urandom();
      H          = 1'($urandom_range(0, 1));
      EVEN       = 1'($urandom_range(0, 1));
      PIX_EN     = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
